// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } rf_arb_state_e;

  typedef struct packed {
    logic                        valid;
    logic [RF_ADDR_W-1:0]        rd;
    logic signed [RF_DATA_W-1:0] data;
  } rf_arb_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// WB / LL request, hazard query and register-file write port bundle.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_rd;
  logic signed [DATA_W-1:0] wb_data;
  logic                     ll_valid;
  logic                     ll_ready;
  logic [ADDR_W-1:0]        ll_rd;
  logic signed [DATA_W-1:0] ll_data;
  logic [ADDR_W-1:0]        q_rs1;
  logic [ADDR_W-1:0]        q_rs2;
  logic                     q_hazard;
  logic                     stall_req;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_rd;
  logic signed [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data, q_rs1, q_rs2,
    input  ll_ready, q_hazard, stall_req, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data, q_rs1, q_rs2,
    output ll_ready, q_hazard, stall_req, rf_we, rf_rd, rf_wdata
  );

endinterface

// File: rtl/rf_arb_fifo.sv
// LL write buffer: circular FIFO with per-entry valid bits that WB writes can kill,
// plus the kill-match and hazard-match vectors over the buffered entries.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_rd_i,
  input  logic signed [DATA_W-1:0] push_data_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [ADDR_W-1:0]        kill_rd_i,
  input  logic [ADDR_W-1:0]        q_rs1_i,
  input  logic [ADDR_W-1:0]        q_rs2_i,
  output logic [CNT_W-1:0]         count_o,
  output logic                     head_valid_o,
  output logic [ADDR_W-1:0]        head_rd_o,
  output logic signed [DATA_W-1:0] head_data_o,
  output logic                     any_valid_o,
  output logic [DEPTH-1:0]         kill_vec_o,
  output logic                     push_killed_o,
  output logic                     hit1_o,
  output logic                     hit2_o
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [ADDR_W-1:0]        rd_q   [DEPTH];
  logic signed [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DEPTH-1:0]         hit1_vec, hit2_vec;

  always_comb begin
    kill_vec_o = '0;
    hit1_vec   = '0;
    hit2_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_vec_o[i] = kill_i && valid_q[i] && (rd_q[i] == kill_rd_i);
      hit1_vec[i]   = valid_q[i] && (rd_q[i] == q_rs1_i);
      hit2_vec[i]   = valid_q[i] && (rd_q[i] == q_rs2_i);
    end
  end

  // An entry entering in the same cycle as a matching WB write is already stale.
  assign push_killed_o = push_i && kill_i && (push_rd_i == kill_rd_i);

  always_comb begin
    valid_d = valid_q & ~kill_vec_o;
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = ~push_killed_o;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign any_valid_o  = |valid_q;
  assign hit1_o       = |hit1_vec;
  assign hit2_o       = |hit2_vec;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB always wins, LL is buffered and drained when WB idles.
// Optional performance counters are built when RF_ARB_PERF_EN is defined.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0]        perf_conflict_o,
  output logic [31:0]        perf_stall_o,
  output logic [15:0]        perf_kill_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0]        ST_NORMAL = 1'(NORMAL);
  localparam logic [0:0]        ST_STARVE = 1'(STARVE);
  localparam logic [ADDR_W-1:0] RD_ZERO   = ADDR_W'(ZERO_REG);

  logic                     wb_win, nonempty, push, pop, ll_grant;
  logic [CNT_W-1:0]         fifo_count;
  logic                     head_valid, any_valid, push_killed, hit1, hit2;
  logic [ADDR_W-1:0]        head_rd;
  logic signed [DATA_W-1:0] head_data;
  logic [DEPTH-1:0]         kill_vec;

  logic                     rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]        rf_rd_q, rf_rd_d;
  logic signed [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic                     stall_q, stall_d;
  logic [0:0]               state_q, state_d;
  logic [SC_W-1:0]          starve_q, starve_d;

  assign wb_win        = bus.wb_valid && (bus.wb_rd != RD_ZERO);
  assign nonempty      = (fifo_count != '0);
  assign bus.ll_ready  = (fifo_count < CNT_W'(DEPTH));
  assign push          = bus.ll_valid && bus.ll_ready && (bus.ll_rd != RD_ZERO);
  // Killed heads are popped too; they just never reach the write port.
  assign pop           = !wb_win && nonempty;
  assign ll_grant      = pop && head_valid;

  rf_arb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_rd_i     (bus.ll_rd),
    .push_data_i   (bus.ll_data),
    .pop_i         (pop),
    .kill_i        (wb_win),
    .kill_rd_i     (bus.wb_rd),
    .q_rs1_i       (bus.q_rs1),
    .q_rs2_i       (bus.q_rs2),
    .count_o       (fifo_count),
    .head_valid_o  (head_valid),
    .head_rd_o     (head_rd),
    .head_data_o   (head_data),
    .any_valid_o   (any_valid),
    .kill_vec_o    (kill_vec),
    .push_killed_o (push_killed),
    .hit1_o        (hit1),
    .hit2_o        (hit2)
  );

  assign bus.q_hazard =
      ((bus.q_rs1 != RD_ZERO) && (hit1 || (rf_we_q && (rf_rd_q == bus.q_rs1)))) ||
      ((bus.q_rs2 != RD_ZERO) && (hit2 || (rf_we_q && (rf_rd_q == bus.q_rs2))));

  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_win) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = bus.wb_rd;
      rf_wdata_d = bus.wb_data;
    end else if (ll_grant) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = head_rd;
      rf_wdata_d = head_data;
    end
  end

  // Starvation tracking: WB keeps winning while LL work waits.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_NORMAL: begin
        if (!nonempty || ll_grant) begin
          starve_d = '0;
        end else if (wb_win && any_valid) begin
          if (starve_q >= SC_W'(STARVE_LIMIT - 1)) begin
            state_d  = ST_STARVE;
            starve_d = SC_W'(STARVE_LIMIT);
          end else begin
            starve_d = starve_q + SC_W'(1);
          end
        end
      end
      default: begin
        if (!nonempty) begin
          state_d  = ST_NORMAL;
          starve_d = '0;
        end
      end
    endcase
    stall_d = (state_d == ST_STARVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
      state_q    <= ST_NORMAL;
      starve_q   <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
      state_q    <= state_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.stall_req = stall_q;

`ifdef RF_ARB_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [31:0] perf_conflict_q, perf_stall_q;
  logic [15:0] perf_kill_q, kill_n;

  always_comb begin
    kill_n = 16'(push_killed);
    for (int i = 0; i < DEPTH; i++) kill_n = kill_n + 16'(kill_vec[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
      perf_kill_q     <= '0;
    end else begin
      if (wb_win && nonempty) perf_conflict_q <= sat_inc32(perf_conflict_q);
      if (stall_q)            perf_stall_q    <= sat_inc32(perf_stall_q);
      perf_kill_q <= sat_add16(perf_kill_q, kill_n);
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_stall_o    = perf_stall_q;
  assign perf_kill_o     = perf_kill_q;
`else
  logic perf_unused;
  assign perf_unused = ^{kill_vec, push_killed};
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus();

`ifdef RF_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_stall;
  logic [15:0] perf_kill;
`endif

  rf_write_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8),
    .DATA_W       (64),
    .ADDR_W       (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef RF_ARB_PERF_EN
    ,
    .perf_conflict_o (perf_conflict),
    .perf_stall_o    (perf_stall),
    .perf_kill_o     (perf_kill)
`endif
  );

  typedef struct {
    logic        wbv;
    logic [4:0]  wbrd;
    logic [63:0] wbd;
    logic        llv;
    logic [4:0]  llrd;
    logic [63:0] lld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_rdy;
    logic        e_hz;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        e_stall;
  } vec_t;

  vec_t tbl[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic wbv, logic [4:0] wbrd, logic [63:0] wbd,
                              logic llv, logic [4:0] llrd, logic [63:0] lld,
                              logic [4:0] rs1, logic [4:0] rs2,
                              logic e_rdy, logic e_hz, logic e_we,
                              logic [4:0] e_rd, logic [63:0] e_data, logic e_stall);
    vec_t v;
    v.wbv = wbv;  v.wbrd = wbrd;  v.wbd = wbd;
    v.llv = llv;  v.llrd = llrd;  v.lld = lld;
    v.rs1 = rs1;  v.rs2 = rs2;
    v.e_rdy = e_rdy;  v.e_hz = e_hz;  v.e_we = e_we;
    v.e_rd = e_rd;  v.e_data = e_data;  v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic wbv, input logic [4:0] wbrd, input logic [63:0] wbd,
                       input logic llv, input logic [4:0] llrd, input logic [63:0] lld,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb_valid = wbv;  bus.wb_rd = wbrd;  bus.wb_data = wbd;
    bus.ll_valid = llv;  bus.ll_rd = llrd;  bus.ll_data = lld;
    bus.q_rs1 = rs1;     bus.q_rs2 = rs2;
  endtask

  // One cycle per row: inputs settle after the edge, combinational outputs are
  // checked before the next edge, registered outputs just after it.
  task automatic apply(input int r, input vec_t v);
    drive(v.wbv, v.wbrd, v.wbd, v.llv, v.llrd, v.lld, v.rs1, v.rs2);
    #1;
    chk("ll_ready", r, 64'(bus.ll_ready), 64'(v.e_rdy));
    chk("q_hazard", r, 64'(bus.q_hazard), 64'(v.e_hz));
    @(posedge clk);
    #1;
    chk("rf_we", r, 64'(bus.rf_we), 64'(v.e_we));
    if (v.e_we) begin
      chk("rf_rd", r, 64'(bus.rf_rd), 64'(v.e_rd));
      chk("rf_wdata", r, 64'(bus.rf_wdata), v.e_data);
    end
    chk("stall_req", r, 64'(bus.stall_req), 64'(v.e_stall));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    rst = 1'b1;
    #12;
    chk("rst_rf_we", -1, 64'(bus.rf_we), 0);
    chk("rst_rf_rd", -1, 64'(bus.rf_rd), 0);
    chk("rst_rf_wdata", -1, bus.rf_wdata, 0);
    chk("rst_stall", -1, 64'(bus.stall_req), 0);
    chk("rst_ll_ready", -1, 64'(bus.ll_ready), 1);
    chk("rst_q_hazard", -1, 64'(bus.q_hazard), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // simultaneous WB and LL: WB first, LL next cycle
    tbl.push_back(mk(1, 5, 'h11, 1, 7, 'h22, 0, 0, 1, 0, 1, 5, 'h11, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 5, 1, 1, 1, 7, 'h22, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 0, 1, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    7, 0, 1, 0, 0, 0, 0,    0));
    // WAW: buffered r9 killed by a younger WB write to r9
    tbl.push_back(mk(1, 4,  'h44, 1, 9, 'hAA, 9, 0, 1, 0, 1, 4,  'h44, 0));
    tbl.push_back(mk(1, 9,  'hBB, 0, 0, 0,    9, 0, 1, 1, 1, 9,  'hBB, 0));
    tbl.push_back(mk(1, 12, 'hCC, 0, 0, 0,    0, 0, 1, 0, 1, 12, 'hCC, 0));
    tbl.push_back(mk(0, 0,  0,    0, 0, 0,    9, 0, 1, 0, 0, 0,  0,    0));
    tbl.push_back(mk(0, 0,  0,    0, 0, 0,    0, 0, 1, 0, 0, 0,  0,    0));
    // WAW against an LL entry pushed in the same cycle
    tbl.push_back(mk(1, 6, 'h66, 1, 6, 'h77, 0, 0, 1, 0, 1, 6, 'h66, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 1, 0, 0, 0, 0,    0));
    // hazard queries against a buffered r3
    tbl.push_back(mk(0, 0,  0,     1, 3, 'h33, 3, 0, 1, 0, 0, 0,  0,     0));
    tbl.push_back(mk(1, 10, 'h100, 0, 0, 0,    3, 4, 1, 1, 1, 10, 'h100, 0));
    tbl.push_back(mk(1, 11, 'h101, 0, 0, 0,    0, 4, 1, 0, 1, 11, 'h101, 0));
    tbl.push_back(mk(0, 0,  0,     0, 0, 0,    0, 3, 1, 1, 1, 3,  'h33,  0));
    tbl.push_back(mk(0, 0,  0,     0, 0, 0,    4, 0, 1, 0, 0, 0,  0,     0));
    // rd=0 on both sides: nothing written, nothing buffered
    tbl.push_back(mk(1, 0, 'h55, 1, 0, 'h66, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0));
    // continuous WB, LL fills the FIFO, starvation stall, then drain
    for (int i = 0; i < 14; i++) begin
      logic        we_e;
      logic [4:0]  rd_e;
      logic [63:0] d_e;
      we_e = (i <= 12);
      rd_e = (i <= 8) ? 5'(16 + i) : 5'(i - 8);
      d_e  = (i <= 8) ? 64'('h100 + i) : 64'('hA0 + i - 8);
      tbl.push_back(mk((i <= 8), 5'(16 + i), 64'('h100 + i),
                       (i <= 4), 5'(i + 1), 64'('hA0 + i + 1), 0, 0,
                       (i <= 3 || i >= 10), 0, we_e, rd_e, d_e,
                       (i >= 8 && i <= 12)));
    end

    for (int r = 0; r < tbl.size(); r++) apply(r, tbl[r]);

    // Reset mid-stream with three LL entries buffered and the stall raised
    for (int c = 0; c < 9; c++) begin
      drive(1, 5'(16 + c), 64'(c), (c < 3), 5'(1 + c), 64'('hD0 + c), 0, 0);
      @(posedge clk);
      #1;
    end
    chk("starve_stall", 100, 64'(bus.stall_req), 1);
    chk("starve_wb_we", 100, 64'(bus.rf_we), 1);
    chk("starve_ll_ready", 100, 64'(bus.ll_ready), 1);
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    #1;
    chk("pre_rst_hazard", 101, 64'(bus.q_hazard), 1);
    rst = 1'b1;
    #1;
    chk("midrst_rf_we", 102, 64'(bus.rf_we), 0);
    chk("midrst_ll_ready", 102, 64'(bus.ll_ready), 1);
    chk("midrst_stall", 102, 64'(bus.stall_req), 0);
    chk("midrst_hazard", 102, 64'(bus.q_hazard), 0);
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_rf_we", 103 + c, 64'(bus.rf_we), 0);
      chk("post_rst_stall", 103 + c, 64'(bus.stall_req), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
